sdcard_loader: RTL and testbench

Parametrised successor to the fixed-range SD-to-RAM init loader. It copies a runtime-selected span of raw SD blocks into word-addressed RAM. Supported word widths are 8, 16 or 32 bits, in either byte order. Transfers are re-triggerable and can start at any block and any RAM base address. It sits between the SdCardCtrl controller, whose handshake pins are exposed, and the RAM/SDRAM write arbiter.

---
 rtl/sdcard_loader_if.sv | 56 +++++
 rtl/sdcard_loader.sv | 215 +++++++++++++++++++++
 tb/tb_sdcard_loader.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdcard_loader_if.sv
// sdcard_loader_if
//   Groups every bus-level signal of the SD-to-RAM loader into one bundle.
//   The signals fall into three groups:
//     - the transfer request and status,
//     - the RAM write port,
//     - the SdCardCtrl handshake.
//   Modports:
//     master : loader side (drives RAM write, SD requests, status)
//     slave  : environment side (drives start/params, RAM acceptance, SD responses)
//   Parameters must match the loader instance connected as master.
interface sdcard_loader_if #(
   parameter int WORD_BYTES = 2,
   parameter int ADDR_W     = 25,
   parameter int LEN_W      = 25
);
   // transfer request / status
   logic                    start;
   logic [31:0]             start_block;
   logic [ADDR_W-1:0]       base_addr;
   logic [LEN_W-1:0]        word_count;
   logic                    busy;
   logic                    done;
   logic                    init_error;
   // RAM write port
   logic                    ram_we;
   logic [ADDR_W-1:0]       ram_address;
   logic [8*WORD_BYTES-1:0] ram_data;
   logic                    ram_op_begun;
   // SdCardCtrl handshake
   logic                    sd_rd;
   logic                    sd_continue;
   logic [31:0]             sd_addr;
   logic [7:0]              sd_data;
   logic                    sd_busy;
   logic                    sd_hndshk_o;
   logic                    sd_hndshk_i;
   logic [15:0]             sd_error;

   modport master (
      input  start, start_block, base_addr, word_count,
      output busy, done, init_error,
      output ram_we, ram_address, ram_data,
      input  ram_op_begun,
      output sd_rd, sd_continue, sd_addr, sd_hndshk_i,
      input  sd_data, sd_busy, sd_hndshk_o, sd_error
   );

   modport slave (
      output start, start_block, base_addr, word_count,
      input  busy, done, init_error,
      input  ram_we, ram_address, ram_data,
      output ram_op_begun,
      input  sd_rd, sd_continue, sd_addr, sd_hndshk_i,
      output sd_data, sd_busy, sd_hndshk_o, sd_error
   );
endinterface

// File: rtl/sdcard_loader.sv
// sdcard_loader
//   Copies a runtime-selected span of raw SD blocks into word-addressed RAM.
//   SD bytes are packed into WORD_BYTES-wide words in the chosen byte order.
//   Each completed word is presented to the RAM arbiter and held until the
//   arbiter accepts it.
//   Ports:
//     clk50 : system clock
//     reset : synchronous, active-high reset
//     bus   : sdcard_loader_if.master, which carries
//               - start/start_block/base_addr/word_count request
//               - busy/done/init_error status
//               - RAM write port (ram_we, ram_address, ram_data, ram_op_begun)
//               - SdCardCtrl handshake (sd_rd, sd_continue, sd_addr, sd_data,
//                 sd_busy, sd_hndshk_o, sd_hndshk_i, sd_error)
//
// state       | meaning
// ------------+-----------------------------------------------------------
// WAIT_INIT   | card power-up; wait for controller to go idle
// IDLE        | ready, waiting for start
// READBLOCK   | request block blk_q, hold until controller reports busy
// GETBYTE     | wait for the next byte or for the end of the block
// ACKBYTE     | acknowledge the byte, wait for the controller to release it
// WRITE       | present the packed word to RAM until ram_op_begun
// DRAIN       | word count reached; wait for discard bytes or end of block
// DRAIN_ACK   | acknowledge a discarded byte
// DONE        | transfer complete; restartable
// ERROR       | controller error; sticky until reset
module sdcard_loader #(
   parameter int WORD_BYTES = 2,
   parameter bit BIG_ENDIAN = 1'b1,
   parameter int ADDR_W     = 25,
   parameter int LEN_W      = 25,
   parameter bit SDHC       = 1'b0
) (
   input logic             clk50,
   input logic             reset,
   sdcard_loader_if.master bus
);

   localparam int         DATA_W   = 8 * WORD_BYTES;
   localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

   typedef enum logic [3:0] {
      S_WAIT_INIT,
      S_IDLE,
      S_READBLOCK,
      S_GETBYTE,
      S_ACKBYTE,
      S_WRITE,
      S_DRAIN,
      S_DRAIN_ACK,
      S_DONE,
      S_ERROR
   } state_t;

   state_t              state_q, state_d;
   logic [31:0]         blk_q, blk_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic [LEN_W-1:0]    remaining_q, remaining_d;
   logic                first_blk_q, first_blk_d;
   logic [1:0]          bidx_q, bidx_d;
   logic [DATA_W-1:0]   word_q, word_d;

   logic                ram_we_c;
   logic                sd_rd_c;
   logic                sd_continue_c;
   logic [31:0]         sd_addr_c;
   logic                sd_hndshk_i_c;
   logic [1:0]          lane;

   // Byte lane receiving the current SD byte within the word.
   assign lane = BIG_ENDIAN ? (LAST_IDX - bidx_q) : bidx_q;

   always_ff @(posedge clk50) begin
      if (reset) begin
         state_q     <= S_WAIT_INIT;
         blk_q       <= '0;
         waddr_q     <= '0;
         remaining_q <= '0;
         first_blk_q <= 1'b0;
         bidx_q      <= '0;
         word_q      <= '0;
      end else begin
         state_q     <= state_d;
         blk_q       <= blk_d;
         waddr_q     <= waddr_d;
         remaining_q <= remaining_d;
         first_blk_q <= first_blk_d;
         bidx_q      <= bidx_d;
         word_q      <= word_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      blk_d         = blk_q;
      waddr_d       = waddr_q;
      remaining_d   = remaining_q;
      first_blk_d   = first_blk_q;
      bidx_d        = bidx_q;
      word_d        = word_q;
      ram_we_c      = 1'b0;
      sd_rd_c       = 1'b0;
      sd_continue_c = 1'b0;
      sd_addr_c     = '0;
      sd_hndshk_i_c = 1'b0;

      case (state_q)
         S_WAIT_INIT: begin
            if (!bus.sd_busy) begin
               state_d = (bus.sd_error != '0) ? S_ERROR : S_IDLE;
            end
         end

         S_IDLE, S_DONE: begin
            if (bus.start) begin
               blk_d       = bus.start_block;
               waddr_d     = bus.base_addr;
               remaining_d = bus.word_count;
               first_blk_d = 1'b1;
               bidx_d      = '0;
               state_d     = (bus.word_count == '0) ? S_DONE : S_READBLOCK;
            end
         end

         S_READBLOCK: begin
            sd_rd_c       = 1'b1;
            sd_continue_c = ~first_blk_q;
            sd_addr_c     = SDHC ? blk_q : {blk_q[22:0], 9'd0};
            if (bus.sd_busy) begin
               first_blk_d = 1'b0;
               state_d     = S_GETBYTE;
            end
         end

         S_GETBYTE: begin
            // Controller going idle here means the block ended with words
            // still owed, so chain straight into the next block.
            if (!bus.sd_busy) begin
               if (bus.sd_error != '0) begin
                  state_d = S_ERROR;
               end else begin
                  blk_d   = blk_q + 32'd1;
                  state_d = S_READBLOCK;
               end
            end else if (bus.sd_hndshk_o) begin
               for (int i = 0; i < WORD_BYTES; i++) begin
                  if (lane == 2'(i)) begin
                     word_d[8*i +: 8] = bus.sd_data;
                  end
               end
               state_d = S_ACKBYTE;
            end
         end

         S_ACKBYTE: begin
            sd_hndshk_i_c = 1'b1;
            if (!bus.sd_hndshk_o) begin
               if (bidx_q == LAST_IDX) begin
                  bidx_d  = '0;
                  state_d = S_WRITE;
               end else begin
                  bidx_d  = bidx_q + 2'd1;
                  state_d = S_GETBYTE;
               end
            end
         end

         S_WRITE: begin
            ram_we_c = 1'b1;
            if (bus.ram_op_begun) begin
               waddr_d     = waddr_q + ADDR_W'(1);
               remaining_d = remaining_q - LEN_W'(1);
               state_d     = (remaining_q == LEN_W'(1)) ? S_DRAIN : S_GETBYTE;
            end
         end

         S_DRAIN: begin
            if (!bus.sd_busy) begin
               state_d = (bus.sd_error != '0) ? S_ERROR : S_DONE;
            end else if (bus.sd_hndshk_o) begin
               state_d = S_DRAIN_ACK;
            end
         end

         S_DRAIN_ACK: begin
            sd_hndshk_i_c = 1'b1;
            if (!bus.sd_hndshk_o) begin
               state_d = S_DRAIN;
            end
         end

         S_ERROR: begin
            state_d = S_ERROR;
         end

         default: begin
            state_d = S_WAIT_INIT;
         end
      endcase
   end

   assign bus.ram_we      = ram_we_c;
   assign bus.ram_address = waddr_q;
   assign bus.ram_data    = word_q;
   assign bus.sd_rd       = sd_rd_c;
   assign bus.sd_continue = sd_continue_c;
   assign bus.sd_addr     = sd_addr_c;
   assign bus.sd_hndshk_i = sd_hndshk_i_c;
   assign bus.done        = (state_q == S_DONE);
   assign bus.init_error  = (state_q == S_ERROR);
   assign bus.busy        = !((state_q == S_WAIT_INIT) || (state_q == S_IDLE) ||
                              (state_q == S_DONE)      || (state_q == S_ERROR));

endmodule

// File: tb/tb_sdcard_loader.sv
// Bench for sdcard_loader.
//   dut0 : 16-bit words, big-endian byte order, byte addressing.
//   dut1 : 32-bit words, little-endian byte order, block addressing.
// One card model and one RAM responder are shared and steered by sel.
// The expected write stream is computed from the SD byte pattern with plain arithmetic.
module tb_sdcard_loader;
   localparam int AW = 25;
   localparam int LW = 25;

   logic clk50 = 1'b0;
   always #10 clk50 = ~clk50;

   logic reset = 1'b1;

   sdcard_loader_if #(.WORD_BYTES(2), .ADDR_W(AW), .LEN_W(LW)) if0 ();
   sdcard_loader_if #(.WORD_BYTES(4), .ADDR_W(AW), .LEN_W(LW)) if1 ();

   sdcard_loader #(.WORD_BYTES(2), .BIG_ENDIAN(1'b1), .ADDR_W(AW), .LEN_W(LW), .SDHC(1'b0))
      dut0 (.clk50(clk50), .reset(reset), .bus(if0.master));
   sdcard_loader #(.WORD_BYTES(4), .BIG_ENDIAN(1'b0), .ADDR_W(AW), .LEN_W(LW), .SDHC(1'b1))
      dut1 (.clk50(clk50), .reset(reset), .bus(if1.master));

   // stimulus state
   bit          sel = 1'b0;
   logic        start_t = 1'b0;
   logic [31:0] start_block_t = '0;
   logic [AW-1:0] base_t = '0;
   logic [LW-1:0] count_t = '0;
   logic        init_busy = 1'b1;
   logic [15:0] sd_error_t = '0;
   logic        card_busy = 1'b0;
   logic        card_hs = 1'b0;
   logic [7:0]  card_data = '0;
   logic        begun_t = 1'b0;

   assign if0.start        = start_t & ~sel;
   assign if1.start        = start_t & sel;
   assign if0.start_block  = start_block_t;
   assign if1.start_block  = start_block_t;
   assign if0.base_addr    = base_t;
   assign if1.base_addr    = base_t;
   assign if0.word_count   = count_t;
   assign if1.word_count   = count_t;
   assign if0.sd_busy      = (init_busy | card_busy) & ~sel;
   assign if1.sd_busy      = (init_busy | card_busy) & sel;
   assign if0.sd_error     = sel ? 16'h0 : sd_error_t;
   assign if1.sd_error     = sel ? sd_error_t : 16'h0;
   assign if0.sd_hndshk_o  = card_hs & ~sel;
   assign if1.sd_hndshk_o  = card_hs & sel;
   assign if0.sd_data      = card_data;
   assign if1.sd_data      = card_data;
   assign if0.ram_op_begun = begun_t & ~sel;
   assign if1.ram_op_begun = begun_t & sel;

   // outputs of the selected DUT
   logic          ram_we_m, busy_m, done_m, err_m, sd_rd_m, sd_cont_m, hsi_m;
   logic [AW-1:0] ram_addr_m;
   logic [31:0]   ram_data_m, sd_addr_m;
   logic          other_we, other_rd;
   logic [6:0]    ctl_m;

   assign ram_we_m   = sel ? if1.ram_we      : if0.ram_we;
   assign ram_addr_m = sel ? if1.ram_address : if0.ram_address;
   assign ram_data_m = sel ? if1.ram_data    : {16'h0, if0.ram_data};
   assign busy_m     = sel ? if1.busy        : if0.busy;
   assign done_m     = sel ? if1.done        : if0.done;
   assign err_m      = sel ? if1.init_error  : if0.init_error;
   assign sd_rd_m    = sel ? if1.sd_rd       : if0.sd_rd;
   assign sd_cont_m  = sel ? if1.sd_continue : if0.sd_continue;
   assign sd_addr_m  = sel ? if1.sd_addr     : if0.sd_addr;
   assign hsi_m      = sel ? if1.sd_hndshk_i : if0.sd_hndshk_i;
   assign other_we   = sel ? if0.ram_we      : if1.ram_we;
   assign other_rd   = sel ? if0.sd_rd       : if1.sd_rd;
   assign ctl_m      = {ram_we_m, busy_m, done_m, err_m, sd_rd_m, sd_cont_m, hsi_m};

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Byte k of SD block b.
   function automatic logic [7:0] sd_byte(input int b, input int k);
      return 8'((k + b) & 255);
   endfunction

   // Word i of a transfer starting at block blk0, wb bytes per word.
   function automatic logic [31:0] exp_word(input int wb, input bit be, input int blk0, input int i);
      logic [31:0] w;
      int j;
      w = '0;
      for (int b = 0; b < wb; b++) begin
         j = i * wb + b;
         if (be) w[8*(wb-1-b) +: 8] = sd_byte(blk0 + j / 512, j % 512);
         else    w[8*b +: 8]        = sd_byte(blk0 + j / 512, j % 512);
      end
      return w;
   endfunction

   typedef struct {
      logic [AW-1:0] a;
      logic [31:0]   d;
   } wr_t;
   wr_t exp_q[$];

   task automatic expect_words(input int wb, input bit be, input int blk0, input int base, input int cnt);
      for (int i = 0; i < cnt; i++) begin
         exp_q.push_back('{a: AW'(base + i), d: exp_word(wb, be, blk0, i)});
      end
   endtask

   // ---------------- SD card model ----------------
   typedef enum {C_IDLE, C_SEND, C_ACK, C_REL} cmode_t;
   cmode_t cmode = C_IDLE;
   int ccnt = 0;
   int cblk = 0;
   int bytes_served = 0;
   int rd_addr_q[$];
   bit rd_cont_q[$];

   always @(negedge clk50) begin
      if (reset) begin
         cmode     = C_IDLE;
         card_busy = 1'b0;
         card_hs   = 1'b0;
      end else begin
         case (cmode)
            C_IDLE: if (sd_rd_m) begin
               rd_addr_q.push_back(int'(sd_addr_m));
               rd_cont_q.push_back(sd_cont_m);
               cblk      = sel ? int'(sd_addr_m) : int'(sd_addr_m >> 9);
               card_busy = 1'b1;
               ccnt      = 0;
               cmode     = C_SEND;
            end
            C_SEND: begin
               card_data = sd_byte(cblk, ccnt);
               card_hs   = 1'b1;
               cmode     = C_ACK;
            end
            C_ACK: if (hsi_m) begin
               card_hs = 1'b0;
               cmode   = C_REL;
            end
            C_REL: if (!hsi_m) begin
               ccnt++;
               bytes_served++;
               if (ccnt == 512) begin
                  card_busy = 1'b0;
                  cmode     = C_IDLE;
               end else begin
                  cmode = C_SEND;
               end
            end
            default: cmode = C_IDLE;
         endcase
      end
   end

   // ---------------- RAM responder + write compare ----------------
   int stall_req = 0;
   bit prev_stall = 1'b0;
   int writes_done = 0;
   logic [31:0] mem_seen [int];

   always @(negedge clk50) begin
      if (reset) begin
         begun_t    = 1'b0;
         prev_stall = 1'b0;
      end else begin
         check("idle_dut_quiet", {30'd0, other_we, other_rd}, 32'd0);
         if (prev_stall) check("stall_hold_we", ram_we_m, 1);
         if (ram_we_m) begin
            if (exp_q.size() == 0) begin
               check("ram_we_unexpected", ram_we_m, 0);
               begun_t    = 1'b0;
               prev_stall = 1'b0;
            end else begin
               check("wr_addr", ram_addr_m, exp_q[0].a);
               check("wr_data", ram_data_m, exp_q[0].d);
               if (stall_req > 0) begin
                  stall_req--;
                  begun_t    = 1'b0;
                  prev_stall = 1'b1;
               end else begin
                  begun_t    = 1'b1;
                  prev_stall = 1'b0;
                  mem_seen[int'(ram_addr_m)] = ram_data_m;
                  void'(exp_q.pop_front());
                  writes_done++;
               end
            end
         end else begin
            begun_t    = 1'b0;
            prev_stall = 1'b0;
         end
      end
   end

   function automatic logic [31:0] seen(input int a);
      return mem_seen.exists(a) ? mem_seen[a] : 32'hDEAD_BEEF;
   endfunction

   // ---------------- sequencing helpers ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk50);
         #2;
      end
   endtask

   task automatic do_start(input int blk, input int base, input int cnt);
      start_block_t = blk;
      base_t        = AW'(base);
      count_t       = LW'(cnt);
      start_t       = 1'b1;
      tick(1);
      start_t       = 1'b0;
   endtask

   task automatic wait_done(input int limit, input string nm);
      int n;
      n = 0;
      while (!done_m && n < limit) begin
         tick(1);
         n++;
      end
      check(nm, done_m, 1);
   endtask

   initial begin
      #10ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rdn, b0, w0, n;

      // reset and power-up
      tick(3);
      check("reset_ctl", ctl_m, 0);
      check("reset_ram_addr", ram_addr_m, 0);
      check("reset_ram_data", ram_data_m, 0);
      check("reset_sd_addr", sd_addr_m, 0);
      reset = 1'b0;
      tick(3);
      check("wait_init_ctl", ctl_m, 0);
      init_busy = 1'b0;
      tick(2);

      // 16-bit big-endian, one full block
      expect_words(2, 1'b1, 0, 'h100, 256);
      rdn = rd_addr_q.size();
      b0  = bytes_served;
      do_start(0, 'h100, 256);
      check("t1_busy", busy_m, 1);
      wait_done(20000, "t1_done");
      check("t1_busy_low", busy_m, 0);
      check("t1_writes_left", exp_q.size(), 0);
      check("t1_rd_count", rd_addr_q.size() - rdn, 1);
      if (rd_addr_q.size() > rdn) begin
         check("t1_rd_addr", rd_addr_q[rdn], 0);
         check("t1_rd_cont", rd_cont_q[rdn], 0);
      end
      check("t1_word_0x100", seen('h100), 32'h0000_0001);
      check("t1_word_0x1ff", seen('h1FF), 32'h0000_FEFF);
      check("t1_bytes", bytes_served - b0, 512);

      // restart from DONE, then reset while acknowledging a byte
      expect_words(2, 1'b1, 0, 'h20, 10);
      b0 = bytes_served;
      do_start(0, 'h20, 10);
      check("restart_done_drop", done_m, 0);
      check("restart_busy", busy_m, 1);
      n = 0;
      while (!(hsi_m && (bytes_served - b0) >= 3) && n < 3000) begin
         tick(1);
         n++;
      end
      check("reach_ackbyte", hsi_m, 1);
      reset     = 1'b1;
      init_busy = 1'b1;
      exp_q.delete();
      tick(1);
      check("abort_ctl", ctl_m, 0);
      check("abort_ram_addr", ram_addr_m, 0);
      check("abort_ram_data", ram_data_m, 0);
      check("abort_sd_addr", sd_addr_m, 0);
      tick(1);
      reset = 1'b0;
      tick(2);
      init_busy = 1'b0;
      tick(2);

      // zero-length transfer from IDLE
      rdn = rd_addr_q.size();
      do_start(5, 'h55, 0);
      check("zero_done", done_m, 1);
      check("zero_busy", busy_m, 0);
      tick(5);
      check("zero_no_rd", rd_addr_q.size() - rdn, 0);
      check("zero_still_done", done_m, 1);

      // new transfer from DONE at base 0
      expect_words(2, 1'b1, 0, 0, 4);
      do_start(0, 0, 4);
      check("base0_done_drop", done_m, 0);
      wait_done(20000, "base0_done");
      check("base0_writes_left", exp_q.size(), 0);
      check("base0_word0", seen(0), 32'h0000_0001);

      // 32-bit little-endian, block addressing, two blocks with drain
      sel = 1'b1;
      tick(2);
      expect_words(4, 1'b0, 7, 'h300, 200);
      rdn = rd_addr_q.size();
      b0  = bytes_served;
      w0  = writes_done;
      do_start(7, 'h300, 200);
      n = 0;
      while ((writes_done - w0) < 10 && n < 5000) begin
         tick(1);
         n++;
      end
      check("t2_progress", (writes_done - w0) >= 10, 1);
      stall_req = 5;
      do_start(99, 'h1234, 5);
      check("t2_midstart_busy", busy_m, 1);
      wait_done(40000, "t2_done");
      check("t2_writes_left", exp_q.size(), 0);
      check("t2_write_count", writes_done - w0, 200);
      check("t2_rd_count", rd_addr_q.size() - rdn, 2);
      if (rd_addr_q.size() >= rdn + 2) begin
         check("t2_rd0_addr", rd_addr_q[rdn], 7);
         check("t2_rd0_cont", rd_cont_q[rdn], 0);
         check("t2_rd1_addr", rd_addr_q[rdn+1], 8);
         check("t2_rd1_cont", rd_cont_q[rdn+1], 1);
      end
      check("t2_first_word", seen('h300), 32'h0A09_0807);
      check("t2_blk8_word", seen('h380), 32'h0B0A_0908);
      check("t2_last_word", seen('h3C7), 32'h2726_2524);
      check("t2_bytes", bytes_served - b0, 1024);

      // controller error at power-up; start ignored afterwards
      reset     = 1'b1;
      init_busy = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(3);
      check("err_wait_init", ctl_m, 0);
      sd_error_t = 16'h0010;
      init_busy  = 1'b0;
      tick(1);
      check("err_init_error", err_m, 1);
      check("err_busy", busy_m, 0);
      rdn = rd_addr_q.size();
      do_start(0, 0, 4);
      tick(3);
      check("err_sticky_ctl", ctl_m, 7'b0001000);
      check("err_no_rd", rd_addr_q.size() - rdn, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
